xband_comma_align: RTL
======================

Name: xband_comma_align

Overview:
- Word-alignment stage directly upstream of the Xband RX 8b/10b decoder. It drives the decoder's 10-bit input word and input valid.
- Takes unaligned 10-bit words from the LVDS deserializer in the clk_10M domain.
- Searches a 20-bit sliding window for the K28.5 comma, locks onto the bit offset, and emits aligned code groups.
- Monitors lock and re-hunts when commas drift.

Parameters:
- LOCK_CNT, 4: consecutive same-offset commas required to declare lock (range 1..15).
- UNLOCK_CNT, 3: consecutive wrong-offset commas while locked that force re-hunt (range 1..15).
- COMMA_P, 10'b0011111010: K28.5 RD- pattern.
- COMMA_N, 10'b1100000101: K28.5 RD+ pattern.

Ports:
- clk_10M  in  1  Xband link clock.
- xband_rst  in  1  asynchronous active-high reset.
- raw_in  in  10  unaligned word from deserializer.
- raw_in_val  in  1  raw_in qualifier.
- data_in_10bit  out  10  aligned code group to the decoder.
- data_in_val  out  1  aligned word valid.
- locked  out  1  alignment locked.
- align_offset  out  4  current bit offset, 0..9.
- comma_det  out  1  1-cycle pulse: comma seen at the current offset while locked.
- lock_loss_cnt  out  16  saturating count of LOCKED->HUNT transitions.

Behaviour:
- Single clock clk_10M. Asynchronous active-high reset xband_rst.
- Reset values:
  - all outputs 0;
  - state HUNT;
  - prev word register 0;
  - match and miss counters 0.
- Window and detection:
  - On each raw_in_val cycle, w[19:0] = {raw_in, prev}, then prev <= raw_in.
  - Candidate k (k = 0..9) is w[k+9:k].
  - A candidate is a comma when it equals COMMA_P or COMMA_N.
  - If several offsets match, the lowest k is taken.
- raw_in_val low: window, state and counters hold; data_in_val = 0 next cycle.
- State HUNT:
  - Comma at offset k: align_offset <= k, match = 1.
  - If LOCK_CNT == 1, go directly to LOCKED; otherwise go to VERIFY.
- State VERIFY:
  - Comma at align_offset: match++. When match reaches LOCK_CNT, go to LOCKED and clear miss.
  - Comma at a different offset j: align_offset <= j, match = 1, stay in VERIFY.
  - Non-comma words are ignored.
- State LOCKED:
  - locked = 1.
  - Comma at align_offset: miss = 0, pulse comma_det.
  - Comma at another offset: miss++. When miss reaches UNLOCK_CNT:
    - go to HUNT;
    - locked = 0 on the next cycle;
    - lock_loss_cnt++, saturating at 16'hFFFF;
    - match = 0.
  - Non-comma words do not change miss.
- Output path, 1-cycle registered latency:
  - data_in_10bit <= w[align_offset+9 : align_offset] whenever raw_in_val is high.
  - data_in_val <= raw_in_val & (state == LOCKED).
  - The word that completes lock is itself emitted valid.
  - The word that triggers unlock is emitted with data_in_val = 0.
- Offset update and data select in the same cycle: data is selected with the offset as it stands before the update.
- Reset asserted mid-stream: immediate return to reset values. The first post-reset window uses prev = 0.

Optional Feature:
- XBAND_ALIGN_STATS_EN defined:
  - lock_loss_cnt counts as specified;
  - an internal 16-bit saturating comma counter (locked commas) is added for ILA probing.
- Not defined:
  - lock_loss_cnt is tied to 16'h0000;
  - no statistics registers are synthesized;
  - all other behaviour is identical.

Test Plan:
- Stream of K28.5 RD- (0011111010) interleaved with data D21.5 (1010101010), bit-rotated by 3 (offset 3), raw_in_val = 1 -> align_offset = 3 after the first comma; locked = 1 after the 4th comma; data_in_10bit shows 0011111010 / 1010101010 one cycle after input.
- Lock at offset 3, then the stream is shifted to offset 7 -> after 3 commas at offset 7, locked falls to 0 and lock_loss_cnt = 1 (STATS_EN). Re-lock at align_offset = 7 after 4 more commas.
- During VERIFY (2 commas at offset 3), a comma arrives at offset 5 -> align_offset = 5, match restarts at 1, lock after 3 further offset-5 commas.
- raw_in_val toggling 1/0 every cycle while locked -> data_in_val follows with 1-cycle delay; aligned content is unchanged; no spurious unlock.
- xband_rst pulsed while locked -> all outputs 0 immediately; state HUNT; re-lock requires LOCK_CNT fresh commas.
- Build without XBAND_ALIGN_STATS_EN and force 5 lock losses -> lock_loss_cnt stays 16'h0000; lock behaviour is identical to the STATS_EN build.

Source files
------------

// File: rtl/xband_comma_align.sv
// Xband RX word aligner: hunts for K28.5 in a 20-bit sliding window, locks onto its bit offset
// and feeds aligned code groups to the 8b/10b decoder. Define XBAND_ALIGN_STATS_EN for statistics counters.
module xband_comma_align #(
   parameter int         LOCK_CNT   = 4,
   parameter int         UNLOCK_CNT = 3,
   parameter logic [9:0] COMMA_P    = 10'b0011111010,
   parameter logic [9:0] COMMA_N    = 10'b1100000101
) (
   input  logic        clk_10M,
   input  logic        xband_rst,
   input  logic [9:0]  raw_in,
   input  logic        raw_in_val,
   output logic [9:0]  data_in_10bit,
   output logic        data_in_val,
   output logic        locked,
   output logic [3:0]  align_offset,
   output logic        comma_det,
   output logic [15:0] lock_loss_cnt
);
   localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

   typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_VERIFY = 2'd1, ST_LOCKED = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [9:0]  prev_q, prev_d;
   logic [3:0]  offset_q, offset_d;
   logic [3:0]  match_q, match_d;
   logic [3:0]  miss_q, miss_d;
   logic [9:0]  data_q, data_d;
   logic        val_q, val_d;
   logic        cdet_q, cdet_d;

   // Highest candidate (k = 9) ends at bit 18, so raw_in[9] only matters one word later via prev.
   logic [18:0] win;
   logic [9:0]  cand_hit;
   logic [3:0]  first_k;
   logic        any_hit;
   logic        at_off;
   logic [9:0]  sel_word;

   assign win    = {raw_in[8:0], prev_q};
   assign prev_d = raw_in_val ? raw_in : prev_q;

   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_cand
         assign cand_hit[gi] = (win[gi +: 10] == COMMA_P) || (win[gi +: 10] == COMMA_N);
      end
   endgenerate

   always_comb begin
      first_k = 4'd0;
      for (int k = 9; k >= 0; k--) begin
         if (cand_hit[k]) first_k = 4'(k);
      end
   end

   assign any_hit = |cand_hit;
   assign at_off  = cand_hit[offset_q];

   always_comb begin
      sel_word = win[9:0];
      for (int k = 1; k < 10; k++) begin
         if (offset_q == 4'(k)) sel_word = win[k +: 10];
      end
   end

   always_ff @(posedge clk_10M or posedge xband_rst) begin
      if (xband_rst) begin
         state_q  <= ST_HUNT;
         prev_q   <= '0;
         offset_q <= '0;
         match_q  <= '0;
         miss_q   <= '0;
         data_q   <= '0;
         val_q    <= 1'b0;
         cdet_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         offset_q <= offset_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         data_q   <= data_d;
         val_q    <= val_d;
         cdet_q   <= cdet_d;
      end
   end

   // A comma at the tracked offset wins over a lower-offset one in the same window.
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      match_d  = match_q;
      miss_d   = miss_q;
      if (raw_in_val) begin
         case (state_q)
            ST_HUNT: begin
               if (any_hit) begin
                  offset_d = first_k;
                  match_d  = 4'd1;
                  if (LOCK_TGT == 4'd1) begin
                     state_d = ST_LOCKED;
                     miss_d  = 4'd0;
                  end else begin
                     state_d = ST_VERIFY;
                  end
               end
            end
            ST_VERIFY: begin
               if (at_off) begin
                  match_d = match_q + 4'd1;
                  if (match_d == LOCK_TGT) begin
                     state_d = ST_LOCKED;
                     miss_d  = 4'd0;
                  end
               end else if (any_hit) begin
                  offset_d = first_k;
                  match_d  = 4'd1;
               end
            end
            ST_LOCKED: begin
               if (at_off) begin
                  miss_d = 4'd0;
               end else if (any_hit) begin
                  miss_d = miss_q + 4'd1;
                  if (miss_d == UNLOCK_TGT) begin
                     state_d = ST_HUNT;
                     match_d = 4'd0;
                     miss_d  = 4'd0;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   // Valid follows the post-update state: the lock-completing word is valid, the unlocking one is not.
   always_comb begin
      data_d = raw_in_val ? sel_word : data_q;
      val_d  = raw_in_val && (state_d == ST_LOCKED);
      cdet_d = raw_in_val && (state_q == ST_LOCKED) && at_off;
   end

   assign data_in_10bit = data_q;
   assign data_in_val   = val_q;
   assign locked        = (state_q == ST_LOCKED);
   assign align_offset  = offset_q;
   assign comma_det     = cdet_q;

`ifdef XBAND_ALIGN_STATS_EN
   logic [15:0] loss_q, loss_d;
   logic [15:0] comma_cnt_q, comma_cnt_d;

   always_comb begin
      loss_d      = loss_q;
      comma_cnt_d = comma_cnt_q;
      if ((state_q == ST_LOCKED) && (state_d == ST_HUNT) && (loss_q != 16'hFFFF))
         loss_d = loss_q + 16'd1;
      if (cdet_d && (comma_cnt_q != 16'hFFFF))
         comma_cnt_d = comma_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_10M or posedge xband_rst) begin
      if (xband_rst) begin
         loss_q      <= '0;
         comma_cnt_q <= '0;
      end else begin
         loss_q      <= loss_d;
         comma_cnt_q <= comma_cnt_d;
      end
   end

   assign lock_loss_cnt = loss_q;
`else
   assign lock_loss_cnt = 16'h0000;
`endif

endmodule
